// File: rtl/m4_video_capture_if.sv
// M4 raw video stream in, one-bit-per-pixel frame RAM write port out.
// The capture block takes the slave side; whoever drives the M4 stream takes the master side.
interface m4_video_capture_if #(
    parameter int ADDR_W = 18
);
    logic              m4_dotclk;
    logic              m4_video;
    logic              m4_hsync;
    logic              m4_vsync;
    logic [ADDR_W-1:0] waddr;
    logic              wdata;
    logic              we;

    modport master (
        output m4_dotclk, m4_video, m4_hsync, m4_vsync,
        input  waddr, wdata, we
    );

    modport slave (
        input  m4_dotclk, m4_video, m4_hsync, m4_vsync,
        output waddr, wdata, we
    );
endinterface

// File: rtl/m4_video_capture.sv
// Samples the asynchronous TRS-80 M4 video stream and writes each captured pixel
// into the frame RAM at row*LINE_STRIDE + col, the layout the VGA reader expects.
module m4_video_capture #(
    parameter int ADDR_W      = 18,
    parameter int LINE_STRIDE = 800,
    parameter int H_SKIP      = 48,
    parameter int H_ACTIVE    = 640,
    parameter int V_SKIP      = 8,
    parameter int V_ACTIVE    = 240,
    parameter bit HSYNC_POL   = 1'b1,
    parameter bit VSYNC_POL   = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    m4_video_capture_if.slave   bus,
    output logic                frame_done,
    output logic                short_line
);

    localparam int H_MAX  = (H_ACTIVE > H_SKIP) ? H_ACTIVE : H_SKIP;
    localparam int C_MAX  = (H_MAX > V_SKIP) ? H_MAX : V_SKIP;
    localparam int CNT_W  = $clog2(C_MAX + 1);
    localparam int ROW_W  = $clog2(V_ACTIVE + 1);

    // Bit positions in the synchronizer vectors
    localparam int B_DOT = 0;
    localparam int B_VID = 1;
    localparam int B_HS  = 2;
    localparam int B_VS  = 3;

    typedef enum logic [2:0] {
        S_WAIT_VS,
        S_VSKIP,
        S_HSKIP,
        S_CAPT,
        S_LINE_END,
        S_FULL
    } state_t;

    logic [3:0]        s1_q, s2_q, s3_q;
    logic [3:0]        raw;
    logic              dot_edge, hs_edge, vs_edge;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic              wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              fd_q, fd_d;
    logic              short_q, short_d;
    logic              line_done;

    assign raw = {bus.m4_vsync, bus.m4_hsync, bus.m4_video, bus.m4_dotclk};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign dot_edge = s2_q[B_DOT] & ~s3_q[B_DOT];
    assign hs_edge  = (s2_q[B_HS] == HSYNC_POL) && (s3_q[B_HS] != HSYNC_POL);
    assign vs_edge  = (s2_q[B_VS] == VSYNC_POL) && (s3_q[B_VS] != VSYNC_POL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_WAIT_VS;
            cnt_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            waddr_q    <= '0;
            wdata_q    <= 1'b0;
            we_q       <= 1'b0;
            fd_q       <= 1'b0;
            short_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            fd_q       <= fd_d;
            short_q    <= short_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        fd_d       = 1'b0;
        short_d    = short_q;
        line_done  = 1'b0;

        // vsync outranks everything: it always restarts the frame from row 0
        if (vs_edge) begin
            fd_d       = (state_q != S_WAIT_VS) && (row_q != '0);
            state_d    = S_VSKIP;
            cnt_d      = '0;
            row_d      = '0;
            row_base_d = '0;
        end else begin
            case (state_q)
                S_WAIT_VS: ;
                S_VSKIP: begin
                    if (hs_edge) begin
                        if (cnt_q == CNT_W'(V_SKIP - 1)) begin
                            state_d = S_HSKIP;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_HSKIP: begin
                    if (dot_edge) begin
                        if (cnt_q == CNT_W'(H_SKIP - 1)) begin
                            state_d = S_CAPT;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_CAPT: begin
                    // hsync before the line is full: drop the rest of this row
                    if (hs_edge) begin
                        short_d   = 1'b1;
                        line_done = 1'b1;
                    end else if (dot_edge) begin
                        we_d    = 1'b1;
                        waddr_d = row_base_q + ADDR_W'(cnt_q);
                        wdata_d = s2_q[B_VID];
                        if (cnt_q == CNT_W'(H_ACTIVE - 1)) begin
                            state_d = S_LINE_END;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_LINE_END: begin
                    if (hs_edge) line_done = 1'b1;
                end
                S_FULL: ;
                default: state_d = S_WAIT_VS;
            endcase

            if (line_done) begin
                row_d      = row_q + 1'b1;
                row_base_d = row_base_q + ADDR_W'(LINE_STRIDE);
                cnt_d      = '0;
                state_d    = (row_q == ROW_W'(V_ACTIVE - 1)) ? S_FULL : S_HSKIP;
            end
        end
    end

    assign bus.waddr  = waddr_q;
    assign bus.wdata  = wdata_q;
    assign bus.we     = we_q;
    assign frame_done = fd_q;
    assign short_line = short_q;

endmodule

// File: tb/tb_m4_video_capture.sv
// Drives a scaled-down M4 video stream and checks the RAM writes against
// expectations computed from row/column arithmetic.
module tb_m4_video_capture;

    localparam int AW = 12;
    localparam int ST = 20;
    localparam int HS = 3;
    localparam int HA = 16;
    localparam int VS = 2;
    localparam int VA = 6;

    typedef struct packed {
        logic [AW-1:0] a;
        logic          d;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_done, short_line;

    int   errors = 0;
    int   checks = 0;
    int   fd_cnt = 0;
    wr_t  got_q[$];
    wr_t  exp_q[$];

    m4_video_capture_if #(.ADDR_W(AW)) bus ();

    m4_video_capture #(
        .ADDR_W(AW), .LINE_STRIDE(ST), .H_SKIP(HS), .H_ACTIVE(HA),
        .V_SKIP(VS), .V_ACTIVE(VA), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave),
        .frame_done(frame_done),
        .short_line(short_line)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.we === 1'b1) got_q.push_back('{a: bus.waddr, d: bus.wdata});
        if (frame_done === 1'b1) fd_cnt++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic dot(input logic v);
        bus.m4_video = v;
        step(1);
        bus.m4_dotclk = 1'b1;
        step(2);
        bus.m4_dotclk = 1'b0;
        step(2);
    endtask

    task automatic hs();
        bus.m4_hsync = 1'b1;
        step(3);
        bus.m4_hsync = 1'b0;
        step(3);
    endtask

    task automatic vs();
        bus.m4_vsync = 1'b1;
        step(3);
        bus.m4_vsync = 1'b0;
        step(3);
    endtask

    task automatic frame_start();
        vs();
        repeat (VS) hs();
    endtask

    // One M4 line: skip dots, npix pixel dots, closing hsync. Rows at or past VA
    // (or negative, meaning capture is not armed) expect no writes.
    task automatic line(input int row, input int npix, input bit alt);
        logic v;
        repeat (HS) dot(1'($urandom_range(0, 1)));
        for (int c = 0; c < npix; c++) begin
            v = alt ? ~c[0] : 1'($urandom_range(0, 1));
            dot(v);
            if (row >= 0 && row < VA && c < HA)
                exp_q.push_back('{a: AW'(row * ST + c), d: v});
        end
        hs();
    endtask

    function automatic int first_diff();
        int n;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (got_q[i] !== exp_q[i]) return i;
        if (got_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic clear_q();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        int idx;
        bus.m4_dotclk = 1'b0; bus.m4_video = 1'b0;
        bus.m4_hsync  = 1'b0; bus.m4_vsync = 1'b0;
        rst_n = 1'b0;
        step(3);
        checks++; if (bus.waddr !== '0) begin errors++; $display("FAIL reset_waddr got=%0d exp=0", bus.waddr); end
        checks++; if (bus.wdata !== 1'b0) begin errors++; $display("FAIL reset_wdata got=%b exp=0", bus.wdata); end
        checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", bus.we); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
        checks++; if (short_line !== 1'b0) begin errors++; $display("FAIL reset_short_line got=%b exp=0", short_line); end
        rst_n = 1'b1;
        step(2);

        // Start a line, then reset while a pixel is still in the synchronizer
        frame_start();
        clear_q();
        repeat (HS) dot(1'b0);
        for (int c = 0; c < 5; c++) begin
            dot(1'b1);
            exp_q.push_back('{a: AW'(c), d: 1'b1});
        end
        bus.m4_video = 1'b1;
        step(1);
        bus.m4_dotclk = 1'b1;
        step(1);
        rst_n = 1'b0;
        step(1);
        checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL reset_midline_we got=%b exp=0", bus.we); end
        step(1);
        checks++; if (bus.waddr !== '0) begin errors++; $display("FAIL reset_midline_waddr got=%0d exp=0", bus.waddr); end
        bus.m4_dotclk = 1'b0;
        rst_n = 1'b1;
        step(2);
        repeat (8) dot(1'b1);
        hs();
        line(-1, HA, 1'b0);
        step(3);
        idx = first_diff();
        checks++; if (idx != -1) begin errors++; $display("FAIL reset_no_writes_after got=%0d writes exp=%0d (first diff %0d)", got_q.size(), exp_q.size(), idx); end

        clear_q();
        frame_start();
        line(0, HA, 1'b0);
        step(3);
        checks++;
        if (got_q.size() == 0 || got_q[0].a !== '0) begin
            errors++; $display("FAIL reset_restart_addr got_n=%0d first=%0d exp=0", got_q.size(), (got_q.size() > 0) ? int'(got_q[0].a) : -1);
        end
        idx = first_diff();
        checks++; if (idx != -1) begin errors++; $display("FAIL reset_restart_line first diff at %0d got_n=%0d exp_n=%0d", idx, got_q.size(), exp_q.size()); end
    endtask

    task automatic test_nominal();
        int fd0, idx;
        frame_start();
        clear_q();
        fd0 = fd_cnt;
        for (int r = 0; r < VA; r++) line(r, HA, 1'b1);
        step(3);
        checks++; if (got_q.size() != HA * VA) begin errors++; $display("FAIL nominal_count got=%0d exp=%0d", got_q.size(), HA * VA); end
        idx = first_diff();
        checks++; if (idx != -1) begin errors++; $display("FAIL nominal_writes first diff at %0d", idx); end
        if (got_q.size() > 0) begin
            checks++; if (got_q[0] !== wr_t'{a: '0, d: 1'b1}) begin errors++; $display("FAIL nominal_first got=%0d/%b exp=0/1", got_q[0].a, got_q[0].d); end
            checks++; if (got_q[$].a !== AW'((VA - 1) * ST + HA - 1)) begin errors++; $display("FAIL nominal_last got=%0d exp=%0d", got_q[$].a, (VA - 1) * ST + HA - 1); end
        end
        checks++; if (fd_cnt != fd0) begin errors++; $display("FAIL nominal_fd_early got=%0d exp=%0d", fd_cnt - fd0, 0); end
        vs();
        checks++; if (fd_cnt != fd0 + 1) begin errors++; $display("FAIL nominal_fd got=%0d exp=1", fd_cnt - fd0); end
    endtask

    task automatic test_latency();
        frame_start();
        line(0, HA, 1'b0);
        repeat (HS) dot(1'b0);
        clear_q();
        bus.m4_video = 1'b1;
        step(1);
        // Drive cycle counts as the first; we must appear in the fourth
        bus.m4_dotclk = 1'b1;
        step(1);
        checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL latency_c2 we=%b exp=0", bus.we); end
        step(1);
        checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL latency_c3 we=%b exp=0", bus.we); end
        step(1);
        checks++;
        if (bus.we !== 1'b1 || bus.wdata !== 1'b1 || bus.waddr !== AW'(ST)) begin
            errors++; $display("FAIL latency_c4 we=%b wdata=%b waddr=%0d exp 1/1/%0d", bus.we, bus.wdata, bus.waddr, ST);
        end
        step(1);
        checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL latency_c5 we=%b exp=0", bus.we); end
        bus.m4_dotclk = 1'b0;
        step(2);
    endtask

    task automatic test_short_line();
        int idx, hit, first_r3;
        checks++; if (short_line !== 1'b0) begin errors++; $display("FAIL short_pre got=%b exp=0", short_line); end
        frame_start();
        clear_q();
        for (int r = 0; r < VA; r++) line(r, (r == 2) ? 7 : HA, 1'b0);
        step(3);
        checks++; if (short_line !== 1'b1) begin errors++; $display("FAIL short_flag got=%b exp=1", short_line); end
        idx = first_diff();
        checks++; if (idx != -1) begin errors++; $display("FAIL short_writes first diff at %0d got_n=%0d exp_n=%0d", idx, got_q.size(), exp_q.size()); end
        hit = 0;
        first_r3 = -1;
        foreach (got_q[i]) begin
            if (got_q[i].a >= AW'(2 * ST + 7) && got_q[i].a <= AW'(2 * ST + HA - 1)) hit++;
            if (first_r3 < 0 && got_q[i].a >= AW'(3 * ST)) first_r3 = int'(got_q[i].a);
        end
        checks++; if (hit != 0) begin errors++; $display("FAIL short_gap got=%0d writes exp=0", hit); end
        checks++; if (first_r3 != 3 * ST) begin errors++; $display("FAIL short_next_row got=%0d exp=%0d", first_r3, 3 * ST); end
        vs();
    endtask

    task automatic test_early_vsync();
        int fd0, idx;
        fd0 = fd_cnt;
        vs();
        checks++; if (fd_cnt != fd0) begin errors++; $display("FAIL early_vs_row0 got=%0d exp=0", fd_cnt - fd0); end
        repeat (VS) hs();
        for (int r = 0; r < 3; r++) line(r, HA, 1'b0);
        vs();
        checks++; if (fd_cnt != fd0 + 1) begin errors++; $display("FAIL early_vs_fd got=%0d exp=1", fd_cnt - fd0); end
        clear_q();
        repeat (VS) hs();
        line(0, HA, 1'b0);
        step(3);
        checks++;
        if (got_q.size() == 0 || got_q[0].a !== '0) begin
            errors++; $display("FAIL early_vs_restart got_n=%0d first=%0d exp=0", got_q.size(), (got_q.size() > 0) ? int'(got_q[0].a) : -1);
        end
        idx = first_diff();
        checks++; if (idx != -1) begin errors++; $display("FAIL early_vs_writes first diff at %0d", idx); end
    endtask

    task automatic test_extra_lines();
        int idx, over;
        frame_start();
        clear_q();
        for (int r = 0; r < VA + 3; r++) line(r, HA + 2, 1'b0);
        step(3);
        checks++; if (got_q.size() != HA * VA) begin errors++; $display("FAIL extra_count got=%0d exp=%0d", got_q.size(), HA * VA); end
        idx = first_diff();
        checks++; if (idx != -1) begin errors++; $display("FAIL extra_writes first diff at %0d", idx); end
        over = 0;
        foreach (got_q[i]) if (got_q[i].a >= AW'(VA * ST)) over++;
        checks++; if (over != 0) begin errors++; $display("FAIL extra_overflow got=%0d writes exp=0", over); end
        vs();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_latency();
        test_short_line();
        test_early_vsync();
        test_extra_lines();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
